// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: MEM-stage data-memory handshake controller and MEM/WB register.
// Non-memory instructions pass through to the MEM/WB outputs in one edge.
// Loads and stores are latched, issued on a registered request and held until
// the memory acknowledges. The pipeline is stalled while the access waits.
// A bounded wait counter aborts accesses the memory never answers.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   memRead, memWrite     MEM-stage access type
//   ALUResult, writeData  address/result and store data
//   WB, writeRegister     write-back control and destination register
//   mem_ack, mem_rdata    memory completion strobe and read data
//   mem_req, mem_we       registered request and write enable
//   mem_addr, mem_wdata   latched address and store data
//   stall                 combinational freeze for PC, IF/ID, ID/EX, EX/MEM
//   WB_output, readData_output, ALUResult_output, writeRegister_output
//                         MEM/WB pipeline register
//   err                   sticky error (read+write conflict or timeout)
module mem_wb_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writeData,
    input  logic [1:0]  WB,
    input  logic [4:0]  writeRegister,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [1:0]  WB_output,
    output logic [31:0] readData_output,
    output logic [31:0] ALUResult_output,
    output logic [4:0]  writeRegister_output,
    output logic        err
);

    // Counter must hold TIMEOUT itself, and is never narrower than 4 bits.
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_wb;
    logic [4:0]    lat_wreg;

    logic access;
    logic timed_out;
    logic start;    // issue a new access
    logic done;     // ack received, retire latched instruction
    logic abort;    // timeout, discard latched instruction
    logic bubble;   // load a bubble into MEM/WB
    logic pass;     // pass current instruction straight to MEM/WB

    assign access    = memRead | memWrite;
    assign timed_out = (cnt >= CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        bubble     = 1'b0;
        pass       = 1'b0;
        case (state)
            S_IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (access) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    bubble     = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    pass = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end else if (timed_out) begin
                    // Release the pipeline in the abort cycle; the
                    // instruction is dropped as a bubble.
                    abort      = 1'b1;
                    bubble     = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    // Wait counter: counts only while remaining in WAIT, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_WAIT && next_state == S_WAIT) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Access latches and request. mem_addr doubles as the latched ALUResult.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_wb    <= '0;
            lat_wreg  <= '0;
            err       <= 1'b0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                // Read wins when both are requested.
                mem_we    <= memWrite & ~memRead;
                mem_addr  <= ALUResult;
                mem_wdata <= writeData;
                lat_wb    <= WB;
                lat_wreg  <= writeRegister;
                if (memRead && memWrite) err <= 1'b1;
            end
            if (done || abort) mem_req <= 1'b0;
            if (abort)         err     <= 1'b1;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            WB_output            <= '0;
            readData_output      <= '0;
            ALUResult_output     <= '0;
            writeRegister_output <= '0;
        end else if (done) begin
            WB_output            <= lat_wb;
            readData_output      <= mem_we ? 32'd0 : mem_rdata;
            ALUResult_output     <= mem_addr;
            writeRegister_output <= lat_wreg;
        end else if (pass) begin
            WB_output            <= WB;
            readData_output      <= '0;
            ALUResult_output     <= ALUResult;
            writeRegister_output <= writeRegister;
        end
    end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// tb_mem_wb_ctrl: self-checking bench for mem_wb_ctrl. Each cycle the expected
// MEM/WB and memory-interface state is pushed to a scoreboard queue when the
// stimulus is driven, then popped and compared one time unit after the edge.
module tb_mem_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite;
    logic [31:0] ALUResult, writeData;
    logic [1:0]  WB;
    logic [4:0]  writeRegister;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall;
    logic [1:0]  WB_output;
    logic [31:0] readData_output, ALUResult_output;
    logic [4:0]  writeRegister_output;
    logic        err;

    mem_wb_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .ALUResult(ALUResult), .writeData(writeData), .WB(WB),
        .writeRegister(writeRegister), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stall(stall), .WB_output(WB_output),
        .readData_output(readData_output), .ALUResult_output(ALUResult_output),
        .writeRegister_output(writeRegister_output), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        ack;
        logic [31:0] rdata;
        logic [1:0]  e_wb;
        logic [31:0] e_alu;
        logic [4:0]  e_wreg;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[5];

    int n_chk = 0;
    int n_err = 0;

    // Reference state of the memory-side latches and error flag.
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic        m_err   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [1:0] wb,
                       input logic [4:0] wreg, input logic ack, input logic [31:0] rdata);
        memRead = rd; memWrite = wr; ALUResult = alu; writeData = wd;
        WB = wb; writeRegister = wreg; mem_ack = ack; mem_rdata = rdata;
    endtask

    // One clock: check stall on the settled inputs, push the expectation,
    // clock, then pop and compare against the registered outputs.
    task automatic cyc(input string nm, input logic st, input logic [1:0] wb,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wreg, input logic req);
        exp_t e;
        #1;
        chk({nm, " stall"}, {31'd0, stall}, {31'd0, st});
        e.wb = wb; e.rd = rd; e.alu = alu; e.wreg = wreg; e.req = req;
        e.we = m_we; e.addr = m_addr; e.wdata = m_wdata; e.err = m_err;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, " WB_output"},       {30'd0, WB_output}, {30'd0, e.wb});
            chk({nm, " readData"},        readData_output, e.rd);
            chk({nm, " ALUResult_out"},   ALUResult_output, e.alu);
            chk({nm, " writeReg_out"},    {27'd0, writeRegister_output}, {27'd0, e.wreg});
            chk({nm, " mem_req"},         {31'd0, mem_req}, {31'd0, e.req});
            chk({nm, " mem_we"},          {31'd0, mem_we}, {31'd0, e.we});
            chk({nm, " mem_addr"},        mem_addr, e.addr);
            chk({nm, " mem_wdata"},       mem_wdata, e.wdata);
            chk({nm, " err"},             {31'd0, err}, {31'd0, e.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b10, 32'h0000000B, 5'd31, 1'b0, 32'h0,        2'b10, 32'h0000000B, 5'd31};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 5'd1,  1'b0, 32'h0,        2'b01, 32'hFFFFFFFF, 5'd1};
        tbl[2] = '{2'b11, 32'h00000000, 5'd0,  1'b1, 32'h0000CAFE, 2'b11, 32'h00000000, 5'd0};
        tbl[3] = '{2'b00, 32'hA5A5A5A5, 5'd16, 1'b0, 32'h0,        2'b00, 32'hA5A5A5A5, 5'd16};
        tbl[4] = '{2'b11, 32'h12345678, 5'd7,  1'b1, 32'h11111111, 2'b11, 32'h12345678, 5'd7};

        // Reset, with a pending read on the inputs: stall must stay low.
        reset = 1'b1;
        drv(1'b1, 1'b0, 32'h44, 32'h0, 2'b11, 5'd3, 1'b0, 32'h0);
        cyc("reset0", 1'b0, 2'b00, 0, 0, 0, 1'b0);
        cyc("reset1", 1'b0, 2'b00, 0, 0, 0, 1'b0);
        reset = 1'b0;

        // Pass-through vectors in IDLE; mem_ack here must be ignored.
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b0, tbl[i].alu, 32'h0, tbl[i].wb, tbl[i].wreg, tbl[i].ack, tbl[i].rdata);
            cyc($sformatf("idle%0d", i), 1'b0, tbl[i].e_wb, 32'h0, tbl[i].e_alu, tbl[i].e_wreg, 1'b0);
        end

        // Load acknowledged in the first WAIT cycle.
        drv(1'b1, 1'b0, 32'h40, 32'h77, 2'b11, 5'd5, 1'b0, 32'h0);
        m_we = 1'b0; m_addr = 32'h40; m_wdata = 32'h77;
        cyc("ld issue", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        drv(1'b0, 1'b0, 32'h999, 32'h0, 2'b01, 5'd9, 1'b1, 32'h0F);
        cyc("ld done", 1'b0, 2'b11, 32'h0F, 32'h40, 5'd5, 1'b0);

        // Store acknowledged after three WAIT cycles.
        drv(1'b0, 1'b1, 32'h80, 32'h1234, 2'b01, 5'd7, 1'b0, 32'h0);
        m_we = 1'b1; m_addr = 32'h80; m_wdata = 32'h1234;
        cyc("st issue", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) cyc($sformatf("st wait%0d", i), 1'b1, 2'b00, 0, 0, 0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 32'hDEAD);
        cyc("st done", 1'b0, 2'b01, 32'h0, 32'h80, 5'd7, 1'b0);

        // Load never acknowledged: 15 stalled WAIT cycles, then abort.
        drv(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 5'd3, 1'b0, 32'h0);
        m_we = 1'b0; m_addr = 32'h100; m_wdata = 32'h0;
        cyc("to issue", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        memRead = 1'b0;
        for (int i = 0; i < 15; i++) cyc($sformatf("to wait%0d", i), 1'b1, 2'b00, 0, 0, 0, 1'b1);
        m_err = 1'b1;
        cyc("to abort", 1'b0, 2'b00, 0, 0, 0, 1'b0);
        drv(1'b0, 1'b0, 32'h5, 32'h0, 2'b10, 5'd2, 1'b1, 32'hBEEF);
        cyc("to idle", 1'b0, 2'b10, 0, 32'h5, 5'd2, 1'b0);

        // Reset in the second WAIT cycle; a later ack is ignored.
        drv(1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 5'd4, 1'b0, 32'h0);
        m_we = 1'b0; m_addr = 32'h300; m_wdata = 32'h0;
        cyc("rw issue", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        memRead = 1'b0;
        cyc("rw wait1", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        reset = 1'b1;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_err = 1'b0;
        cyc("rw reset", 1'b0, 2'b00, 0, 0, 0, 1'b0);
        reset = 1'b0;
        drv(1'b0, 1'b0, 32'h6, 32'h0, 2'b10, 5'd8, 1'b1, 32'h55);
        cyc("rw after", 1'b0, 2'b10, 0, 32'h6, 5'd8, 1'b0);

        // Read and write together: read performed, err set at issue.
        drv(1'b1, 1'b1, 32'h200, 32'h99, 2'b11, 5'd12, 1'b0, 32'h0);
        m_we = 1'b0; m_addr = 32'h200; m_wdata = 32'h99; m_err = 1'b1;
        cyc("rw2 issue", 1'b1, 2'b00, 0, 0, 0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 32'hAB);
        cyc("rw2 done", 1'b0, 2'b11, 32'hAB, 32'h200, 5'd12, 1'b0);
        mem_ack = 1'b0;
        cyc("rw2 idle", 1'b0, 2'b00, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_ctrl.md
MEM_WB_CTRL -- requirements
Module: mem_wb_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum WAIT cycles without mem_ack before the access is aborted.
REQ-002 clk  in  1  single clock; every register updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 memRead  in  1  current MEM-stage instruction reads data memory.
REQ-005 memWrite  in  1  current MEM-stage instruction writes data memory.
REQ-006 ALUResult  in  32  memory address for loads/stores; result for all other instructions.
REQ-007 writeData  in  32  store data.
REQ-008 WB  in  2  write-back control bits of the current MEM-stage instruction.
REQ-009 writeRegister  in  5  destination register number.
REQ-010 mem_ack  in  1  memory completion strobe, sampled only in WAIT.
REQ-011 mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-012 mem_req  out  1  access request, registered.
REQ-013 mem_we  out  1  1 = write access.
REQ-014 mem_addr  out  32  latched address.
REQ-015 mem_wdata  out  32  latched store data.
REQ-016 stall  out  1  combinational; freezes PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-017 WB_output  out  2  registered MEM/WB write-back control.
REQ-018 readData_output  out  32  registered load data.
REQ-019 ALUResult_output  out  32  registered ALU result.
REQ-020 writeRegister_output  out  5  registered destination register.
REQ-021 err  out  1  sticky error flag.

Function
REQ-022 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-023 IDLE, no access (memRead=memWrite=0): stall=0; at the clock edge, outputs load WB, ALUResult and writeRegister, and readData_output loads 0 (zero-latency pass-through).
REQ-024 IDLE, access requested: the block SHALL latch WB, ALUResult, writeData, writeRegister and memWrite; assert stall=1; load a bubble at the edge (WB_output=00, all other data outputs 0); set mem_req=1; go to WAIT.
REQ-025 IDLE with memRead=memWrite=1: the block SHALL perform a read only (mem_we=0) and set err at the same edge.
REQ-026 WAIT: mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable from the latches; stall=!mem_ack.
REQ-027 WAIT, mem_ack=0: outputs SHALL load a bubble each cycle, and the wait counter SHALL increment.
REQ-028 WAIT, mem_ack=1: at the edge, outputs SHALL load the latched WB, ALUResult and writeRegister; readData_output SHALL load mem_rdata for a read or 0 for a write; mem_req SHALL drop; go to IDLE; clear the counter.
REQ-029 Minimum latency: with mem_ack in the first WAIT cycle, exactly one stall cycle occurs, and the result appears 2 edges after the instruction reaches IDLE.
REQ-030 Timeout: if the counter reaches TIMEOUT in WAIT with mem_ack=0, the block SHALL set stall=0 that cycle, load a bubble at the edge, drop mem_req, set err and go to IDLE; the instruction is discarded.
REQ-031 mem_ack sampled in IDLE SHALL be ignored.
REQ-032 The wait counter SHALL be 4 bits wide minimum, SHALL saturate (never wrap), and SHALL only count in WAIT.
REQ-033 err SHALL remain 1 until reset.

Reset
REQ-034 When reset=1 at an edge: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; WB_output=00; readData_output=0, ALUResult_output=0, writeRegister_output=0; counter=0; err=0.
REQ-035 stall SHALL be 0 while reset=1.
REQ-036 Reset in WAIT SHALL abandon the access with no write-back and mem_req=0 at the next cycle.

Verification
REQ-037 ALU op WB=10, ALUResult=0x0B, writeRegister=31, no mem -> next edge: WB_output=10, ALUResult_output=0x0B, readData_output=0, stall=0 throughout.
REQ-038 Load, ALUResult=0x40, mem_ack in the first WAIT cycle with mem_rdata=0x0F -> stall=1 for 1 cycle, mem_addr=0x40, then WB_output=11, readData_output=0x0F.
REQ-039 Store, writeData=0x1234, mem_ack after 3 WAIT cycles -> mem_we=1 and mem_wdata=0x1234 held; 4 bubble cycles; then readData_output=0.
REQ-040 Load, mem_ack never asserted, TIMEOUT=15 -> after 15 WAIT cycles mem_req=0, err=1, WB_output=00, FSM returns to IDLE.
REQ-041 reset=1 asserted in the 2nd WAIT cycle -> all outputs 0, state IDLE, and a later mem_ack is ignored.
REQ-042 memRead=memWrite=1 -> mem_we=0, err=1, and the read completes normally.
